strength_sort_bank: RTL

Parametrised successor to the fixed 32-slot sort register. It stores DEPTH tagged strength entries, each written at the slot named by its own index, and tracks which slots are filled. It starts counting when every slot is valid, not only when the top slot is written. It then drains the entries in ascending index order over a valid/ready stream, clears itself, and re-arms. It sits between the strength/average stage and the downstream counting/sorting stage.

---
 rtl/strength_sort_bank_if.sv | 41 ++++
 rtl/strength_sort_bank.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/strength_sort_bank_if.sv
// Stream interface for strength_sort_bank: indexed write port, drain stream
// with valid/ready, and status outputs. The bank connects via the slave
// modport; the producer/consumer side uses master.
interface strength_sort_bank_if #(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 22
);
    // write side
    logic              wr_en;
    logic [IDX_W-1:0]  wr_index;
    logic              wr_gd;
    logic              wr_bd;
    logic [DATA_W-1:0] wr_data;

    // status
    logic              start_count;
    logic [IDX_W:0]    fill_count;
    logic              busy;
    logic              dup_err;

    // drain stream
    logic              rd_valid;
    logic              rd_ready;
    logic [IDX_W-1:0]  rd_index;
    logic              rd_gd;
    logic              rd_bd;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport slave (
        input  wr_en, wr_index, wr_gd, wr_bd, wr_data, rd_ready,
        output start_count, fill_count, busy, dup_err,
        output rd_valid, rd_index, rd_gd, rd_bd, rd_data, rd_last
    );

    modport master (
        output wr_en, wr_index, wr_gd, wr_bd, wr_data, rd_ready,
        input  start_count, fill_count, busy, dup_err,
        input  rd_valid, rd_index, rd_gd, rd_bd, rd_data, rd_last
    );
endinterface

// File: rtl/strength_sort_bank.sv
// strength_sort_bank: DEPTH-slot tagged strength store. Entries are written
// at their own index; once every slot is valid the bank pulses start_count,
// drains slots 0..DEPTH-1 over a valid/ready stream, clears and re-arms.
// Optional feature macro: STRENGTH_SORT_BANK_DUP_CHECK_EN -- when defined, a
// write to an already-valid slot is dropped and flagged on dup_err.
module strength_sort_bank #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 22
) (
    input  logic                 clk,
    input  logic                 reset,
    strength_sort_bank_if.slave  bus
);
    localparam int                WORD_W   = DATA_W + 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DEPTH-1:0]  valid_reg, valid_next;
    logic [IDX_W:0]    fill_count_reg, fill_count_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic              wr_accept;
    logic              slot_was_valid;

    // {bd, gd, data}; contents deliberately not reset, only valid_reg is
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_word_reg;

`ifdef STRENGTH_SORT_BANK_DUP_CHECK_EN
    logic              dup_hit;
    logic              dup_err_reg;
`endif

    // Next-state and bookkeeping: fill tracking, FULL handoff, drain pointer
    always_comb begin
        state_next      = state_reg;
        valid_next      = valid_reg;
        fill_count_next = fill_count_reg;
        ptr_next        = ptr_reg;
        wr_accept       = 1'b0;
`ifdef STRENGTH_SORT_BANK_DUP_CHECK_EN
        dup_hit         = 1'b0;
`endif
        slot_was_valid  = valid_reg[bus.wr_index];

        case (state_reg)
            ST_FILL: begin
                if (bus.wr_en) begin
`ifdef STRENGTH_SORT_BANK_DUP_CHECK_EN
                    if (slot_was_valid) begin
                        dup_hit = 1'b1;
                    end else begin
                        wr_accept = 1'b1;
                    end
`else
                    wr_accept = 1'b1;
`endif
                end
                if (wr_accept) begin
                    valid_next[bus.wr_index] = 1'b1;
                    // a rewrite keeps the count; only fresh slots add to it
                    if (!slot_was_valid) begin
                        fill_count_next = fill_count_reg + 1'b1;
                    end
                end
                // counting starts on a complete bank, regardless of write order
                if (&valid_next) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                state_next = ST_DRAIN;
                ptr_next   = '0;
            end
            ST_DRAIN: begin
                if (bus.rd_ready) begin
                    if (ptr_reg == LAST_IDX) begin
                        valid_next      = '0;
                        fill_count_next = '0;
                        ptr_next        = '0;
                        state_next      = ST_FILL;
                    end else begin
                        ptr_next = ptr_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Control state register; reset aborts any fill or drain in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_FILL;
            valid_reg      <= '0;
            fill_count_reg <= '0;
            ptr_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            valid_reg      <= valid_next;
            fill_count_reg <= fill_count_next;
            ptr_reg        <= ptr_next;
        end
    end

    // Storage write port; only accepted FILL-state writes land in the array
    always_ff @(posedge clk) begin
        if (wr_accept && !reset) begin
            mem[bus.wr_index] <= {bus.wr_bd, bus.wr_gd, bus.wr_data};
        end
    end

    // Registered read addressed by the upcoming pointer, so the word for the
    // presented slot is ready in the same cycle the pointer reaches it
    always_ff @(posedge clk) begin
        rd_word_reg <= mem[ptr_next];
    end

`ifdef STRENGTH_SORT_BANK_DUP_CHECK_EN
    // Duplicate flag appears the cycle after the offending edge
    always_ff @(posedge clk) begin
        if (reset) begin
            dup_err_reg <= 1'b0;
        end else begin
            dup_err_reg <= dup_hit;
        end
    end
    assign bus.dup_err = dup_err_reg;
`else
    assign bus.dup_err = 1'b0;
`endif

    assign bus.start_count = (state_reg == ST_FULL);
    assign bus.busy        = (state_reg != ST_FILL);
    assign bus.fill_count  = fill_count_reg;
    assign bus.rd_valid    = (state_reg == ST_DRAIN);

    // read fields are forced to zero whenever nothing is presented
    assign bus.rd_index = bus.rd_valid ? ptr_reg : '0;
    assign bus.rd_data  = bus.rd_valid ? rd_word_reg[DATA_W-1:0] : '0;
    assign bus.rd_gd    = bus.rd_valid & rd_word_reg[DATA_W];
    assign bus.rd_bd    = bus.rd_valid & rd_word_reg[DATA_W+1];
    assign bus.rd_last  = bus.rd_valid & (ptr_reg == LAST_IDX);

endmodule
